stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel stream multiplexer with round-robin arbitration, per-channel conditional bit inversion and a registered output stage. It generalises the two-input select mux from a combinational gate to a flow-controlled, multi-channel datapath block. Inversion is a mux between the data and its complement, selected per channel. It sits between several independent valid/ready producers and a single downstream consumer.

## Interface
- `N_CH`, default 4: number of input channels, must be at least 2.
- `WIDTH`, default 8: data width in bits, must be at least 1.
- `CH_W`, default `$clog2(N_CH)`: channel-index width. Derived; do not override.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low. One clock domain; asynchronous assert, active-low, as decided.
- `in_valid` input `N_CH`: per-channel valid.
- `in_ready` output `N_CH`: per-channel ready.
- `in_data` input `N_CH*WIDTH`: packed; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `inv_mask` input `N_CH`: bit i set inverts channel i's data on acceptance.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the beat.
- `out_data` output `WIDTH`: registered data after conditional inversion.
- `out_ch` output `CH_W`: source channel of the current beat.

## Operation
- Transfer on any port occurs when valid and ready are both 1 at a rising edge.
- Single-beat transactions; there is no packet locking.
- Free condition: `free = !out_valid || out_ready`.
- Arbitration:
  - Round-robin pointer `last`; search starts at `last+1` and wraps modulo `N_CH`.
  - The first channel with `in_valid` high is the grant `g`.
- `in_ready[i] = free && (i == g) && |in_valid`.
  - At most one `in_ready` bit is high.
  - `in_ready` depends combinationally on `in_valid` and `out_ready`.
  - `in_ready` does not depend on `in_data`.
- On acceptance of channel g:
  - `out_data <= in_data[g] ^ {WIDTH{inv_mask[g]}}`.
  - `out_ch <= g`.
  - `out_valid <= 1`.
  - `last <= g`.
- `inv_mask` is sampled only in the acceptance cycle. Later changes do not alter a held beat.
- Output handshake completes with no new acceptance: `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- While `out_valid && !out_ready`: `out_data`, `out_ch` and `out_valid` are stable, and all `in_ready` are 0.
- `last` is unchanged in any cycle with no acceptance.
- Fairness: with all channels continuously valid and `out_ready` held at 1, grants go 0,1,…,N_CH-1,0,…
- A channel that drops `in_valid` before being granted loses nothing; it is simply skipped.
- Reset (async assert, synchronous-deassert usage assumed by the integrator):
  - `out_valid = 0`, `out_data = 0`, `out_ch = 0`.
  - `last = N_CH-1`, so channel 0 wins first.
  - An in-flight beat is discarded.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready` is held at 1. Acceptance and output drain happen in the same cycle.
- Combinational paths:
  - `out_ready` → `in_ready`.
  - `in_valid` → `in_ready`.
  - No combinational path from inputs to `out_*`.
- Simultaneous events: output drain plus new acceptance in the same cycle leaves `out_valid` at 1 with new data, with no bubble.
- `rst_n` low overrides every other event in every cycle.

## Structure
- Package `stream_mux_pkg` contains:
  - the `rr_next` function: cyclic first-set search from `last+1`, returning index and found flag;
  - a localparam helper for `CH_W`.
- Sub-module `rr_arbiter`, parameter `N_CH`:
  - Inputs: `clk`, `rst_n`, `req[N_CH]`, `advance`.
  - Outputs: one-hot `gnt[N_CH]`, `gnt_idx[CH_W]`.
  - Owns the `last` register.
  - The top asserts `advance` on acceptance.
- The top holds the inversion mux and the output register.

## Test plan
- Reset:
  - Stimulus: `rst_n` low mid-stream with `out_valid` at 1.
  - Response: immediately `out_valid=0`, `out_data=0`, `out_ch=0`.
  - After release, with all valid, first grant is channel 0.
- Round-robin:
  - Stimulus: `N_CH=4`, all `in_valid=1`, `out_ready=1`, `in_data[i]=8'h10+i`, mask 0.
  - Response: `out_data` sequence 10,11,12,13,10, one per cycle, no bubbles.
- Inversion:
  - Stimulus: channel 2 only, `in_data=8'hA5`, `inv_mask=4'b0100`.
  - Response: `out_data=8'h5A`, `out_ch=2`.
  - Toggling the mask after acceptance leaves `out_data` unchanged.
- Backpressure:
  - Stimulus: `out_ready=0` for 3 cycles with beat `8'h33` held.
  - Response: output stable and all `in_ready=0`.
  - Raising `out_ready` transfers `8'h33` and the next beat appears the following cycle.
- Sparse requests:
  - Stimulus: `last=1`, only channels 0 and 3 valid.
  - Response: grant 3, then 0.
  - A channel dropping valid before grant is skipped.
- Parameter sweep:
  - `N_CH`=2,3,5 and `WIDTH`=1,16 with random valid/ready.
  - Scoreboard check: per-channel ordering and inversion correct, no loss or duplication.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer: channel-index
// width derivation and the cyclic first-set search used by the arbiter.
package stream_mux_pkg;

  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int ch_w_of(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  localparam int DEFAULT_CH_W = ch_w_of(4);

  // Scan req starting one past last, wrapping at n_ch; the first set bit wins.
  function automatic rr_pick_t rr_next(input logic [MAX_CH-1:0] req,
                                       input int                n_ch,
                                       input int                last);
    rr_pick_t pick;
    int       i;
    pick = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n_ch) begin
        i = last + k;
        if (i >= n_ch) i = i - n_ch;
        if (!pick.found && req[IDX_W'(i)]) begin
          pick.found = 1'b1;
          pick.idx   = IDX_W'(i);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// with the priority pointer advancing to the winner on each accepted grant.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w_of(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] last;
  rr_pick_t        pick;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt     = '0;
    pick    = rr_next(MAX_CH'(req), N_CH, int'(last));
    gnt_idx = pick.idx[CH_W-1:0];
    for (int i = 0; i < N_CH; i++) begin
      gnt[i] = pick.found && (gnt_idx == CH_W'(i));
    end
  end

  // Reset points at the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      last <= CH_W'(N_CH - 1);
    end else if (advance) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer: round-robin arbitration, per-channel
// conditional inversion at acceptance, and a single registered output beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = ch_w_of(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       inv_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch
);

  logic             free;
  logic             accept;
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_inv;
  logic [WIDTH-1:0] beat_data;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The output slot is free when empty or being drained this cycle.
  assign free     = !out_valid || out_ready;
  assign accept   = free && (|in_valid);
  assign in_ready = {N_CH{free}} & gnt;

  always_comb begin
    sel_data = '0;
    sel_inv  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_inv  = inv_mask[i];
      end
    end
  end

  assign beat_data = sel_inv ? ~sel_data : sel_data;

  // Data and channel hold their last values once the beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios on a 4x8 instance
// with a reference scoreboard, plus randomized sweeps on other geometries.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  inv_mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        sweep_go = 1'b0;

  int total;
  int bad;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } beat_t;

  beat_t      sb[$];
  beat_t      exp_beat;
  int         m_last;
  logic       m_ov;
  logic [3:0] exp_rdy;
  logic [3:0] obs_rdy;
  logic       obs_valid;
  logic [7:0] obs_data;
  logic [1:0] obs_ch;
  logic       drain;
  logic       have_exp;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inv_mask  (inv_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  // Randomized sweeps on other geometries; each keeps its own counts.
  for (genvar c = 0; c < 3; c++) begin : sw
    localparam int CFG   = c;
    localparam int N     = (c == 0) ? 2 : (c == 1) ? 3 : 5;
    localparam int W     = (c == 1) ? 1 : 16;
    localparam int CW    = $clog2(N);
    localparam int ITEMS = 30;

    logic [N-1:0]   v = '0;
    logic [N-1:0]   r;
    logic [N-1:0]   m = '0;
    logic [N*W-1:0] d = '0;
    logic           ordy = 1'b0;
    logic           ov;
    logic [W-1:0]   od;
    logic [CW-1:0]  och;
    logic [W-1:0]   expq[N][$];
    logic [W-1:0]   cur[N];
    int             sent[N];
    int             tot;
    int             s_last;
    logic           s_ov;
    int             n_chk = 0;
    int             n_bad = 0;
    logic           done = 1'b0;

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v),
      .in_ready  (r),
      .in_data   (d),
      .inv_mask  (m),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od),
      .out_ch    (och)
    );

    task automatic sw_cycle(input logic drive);
      int         g;
      int         j;
      logic       free;
      logic [N-1:0] er;
      logic [W-1:0] e;
      for (int i = 0; i < N; i++) begin
        v[i] = drive && (sent[i] < ITEMS) && ($urandom_range(0, 2) != 0);
        d[i*W +: W] = cur[i];
      end
      m    = N'($urandom);
      ordy = drive ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      free = !s_ov || ordy;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        j = (s_last + k) % N;
        if (g < 0 && v[j]) g = j;
      end
      er = (free && g >= 0) ? (N'(1) << g) : '0;
      n_chk++;
      if (r !== er || ov !== s_ov) begin
        n_bad++;
        $display("FAIL sweep%0d handshake: ready=%b valid=%b want ready=%b valid=%b", CFG, r, ov, er, s_ov);
      end
      if (s_ov && ordy) begin
        n_chk++;
        if (int'(och) >= N) begin
          n_bad++;
          $display("FAIL sweep%0d channel: got %0d want below %0d", CFG, och, N);
        end else if (expq[och].size() == 0) begin
          n_bad++;
          $display("FAIL sweep%0d duplicate: got ch%0d data %h want no beat", CFG, och, od);
        end else begin
          e = expq[och].pop_front();
          if (od !== e) begin
            n_bad++;
            $display("FAIL sweep%0d data ch%0d: got %h want %h", CFG, och, od, e);
          end
        end
      end
      if (free && g >= 0) begin
        expq[g].push_back(cur[g] ^ {W{m[g]}});
        sent[g]++;
        tot++;
        cur[g] = W'($urandom);
        s_last = g;
        s_ov   = 1'b1;
      end else if (ordy) begin
        s_ov = 1'b0;
      end
      @(negedge clk);
    endtask

    initial begin
      int left;
      tot    = 0;
      s_last = N - 1;
      s_ov   = 1'b0;
      for (int i = 0; i < N; i++) begin
        cur[i]  = W'($urandom);
        sent[i] = 0;
      end
      wait (sweep_go);
      @(negedge clk);
      for (int cyc = 0; cyc < 4000 && tot < N * ITEMS; cyc++) sw_cycle(1'b1);
      repeat (3) sw_cycle(1'b0);
      left = 0;
      for (int i = 0; i < N; i++) left += expq[i].size();
      n_chk++;
      if (left != 0 || tot != N * ITEMS) begin
        n_bad++;
        $display("FAIL sweep%0d loss: sent=%0d pending=%0d want sent=%0d pending=0", CFG, tot, left, N * ITEMS);
      end
      done = 1'b1;
    end
  end

  // One cycle against the reference: inputs are already driven just after negedge.
  task automatic step();
    int   g;
    int   j;
    logic free;
    #1;
    free = !m_ov || out_ready;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      j = (m_last + k) % 4;
      if (g < 0 && in_valid[j]) g = j;
    end
    exp_rdy   = (free && g >= 0) ? (4'b0001 << g) : 4'b0000;
    obs_rdy   = in_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_ch    = out_ch;
    drain     = m_ov && out_ready;
    have_exp  = 1'b0;
    if (drain && sb.size() > 0) begin
      exp_beat = sb.pop_front();
      have_exp = 1'b1;
    end
    if (free && g >= 0) begin
      sb.push_back('{ch: g, data: in_data[g*8 +: 8] ^ {8{inv_mask[g]}}});
      m_last = g;
      m_ov   = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    inv_mask  = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 3;
    m_ov   = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    inv_mask  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_init: valid=%b data=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 3;
    m_ov   = 1'b0;
    sb.delete();
    in_valid      = 4'b0010;
    in_data[15:8] = 8'h77;
    step();
    in_valid = '0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_load: valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_async: valid=%b data=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 3;
    m_ov   = 1'b0;
    sb.delete();
    in_valid  = 4'b1111;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    step();
    total++;
    if (obs_rdy !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: ready=%b want 0001", obs_rdy);
    end
    in_valid = '0;
    step();
    total++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h10 || obs_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_beat: valid=%b data=%h ch=%0d want 1/10/0", obs_valid, obs_data, obs_ch);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] seq[5];
    seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    in_data   = 32'h13121110;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (obs_rdy !== (4'b0001 << (k % 4))) begin
        bad++;
        $display("FAIL rr_grant%0d: ready=%b want %b", k, obs_rdy, 4'b0001 << (k % 4));
      end
      if (k > 0) begin
        total++;
        if (obs_valid !== 1'b1 || obs_data !== seq[k-1]) begin
          bad++;
          $display("FAIL rr_beat%0d: valid=%b data=%h want 1/%h", k, obs_valid, obs_data, seq[k-1]);
        end
      end
    end
    in_valid = '0;
    step();
    total++;
    if (!have_exp || obs_data !== exp_beat.data || obs_data !== 8'h11) begin
      bad++;
      $display("FAIL rr_tail: data=%h want 11", obs_data);
    end
  endtask

  task automatic test_inversion();
    do_reset();
    in_valid  = 4'b0100;
    in_data   = 32'h00A50000;
    inv_mask  = 4'b0100;
    out_ready = 1'b0;
    step();
    in_valid = '0;
    inv_mask = 4'b0000;
    step();
    total++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h5A || obs_ch !== 2'd2) begin
      bad++;
      $display("FAIL inv_beat: valid=%b data=%h ch=%0d want 1/5a/2", obs_valid, obs_data, obs_ch);
    end
    inv_mask = 4'b1111;
    step();
    total++;
    if (obs_data !== 8'h5A) begin
      bad++;
      $display("FAIL inv_mask_toggle: data=%h want 5a", obs_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (!have_exp || obs_data !== exp_beat.data || obs_ch !== 2'(exp_beat.ch)) begin
      bad++;
      $display("FAIL inv_drain: data=%h ch=%0d want %h/%0d", obs_data, obs_ch, exp_beat.data, exp_beat.ch);
    end
    step();
    total++;
    if (obs_valid !== 1'b0) begin
      bad++;
      $display("FAIL inv_idle: valid=%b want 0", obs_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid      = 4'b0010;
    in_data[15:8] = 8'h33;
    out_ready     = 1'b0;
    step();
    in_valid       = 4'b1000;
    in_data[31:24] = 8'h44;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (obs_valid !== 1'b1 || obs_data !== 8'h33 || obs_ch !== 2'd1 || obs_rdy !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ch=%0d ready=%b want 1/33/1/0000", k, obs_valid, obs_data, obs_ch, obs_rdy);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (obs_data !== 8'h33 || obs_rdy !== 4'b1000) begin
      bad++;
      $display("FAIL bp_release: data=%h ready=%b want 33/1000", obs_data, obs_rdy);
    end
    in_valid = '0;
    step();
    total++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h44 || obs_ch !== 2'd3) begin
      bad++;
      $display("FAIL bp_next: valid=%b data=%h ch=%0d want 1/44/3", obs_valid, obs_data, obs_ch);
    end
  endtask

  task automatic test_sparse();
    logic [3:0] v_tab[9];
    logic       o_tab[9];
    logic [3:0] r_tab[9];
    v_tab = '{4'b0011, 4'b0011, 4'b1001, 4'b1001, 4'b0110, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
    o_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    r_tab = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    in_data = 32'hC3B2A190;
    for (int k = 0; k < 9; k++) begin
      in_valid  = v_tab[k];
      out_ready = o_tab[k];
      inv_mask  = 4'(k);
      step();
      total++;
      if (obs_rdy !== r_tab[k] || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL sparse_grant%0d: ready=%b want %b", k, obs_rdy, r_tab[k]);
      end
      if (drain) begin
        total++;
        if (!have_exp || obs_data !== exp_beat.data || obs_ch !== 2'(exp_beat.ch)) begin
          bad++;
          $display("FAIL sparse_beat%0d: data=%h ch=%0d want %h/%0d", k, obs_data, obs_ch, exp_beat.data, exp_beat.ch);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sparse_pending: left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_param_sweep();
    logic all_done;
    all_done = 1'b0;
    sweep_go = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      all_done = sw[0].done && sw[1].done && sw[2].done;
      if (all_done) break;
      @(negedge clk);
    end
    if (!all_done) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout: done=%b%b%b want 111", sw[2].done, sw[1].done, sw[0].done);
    end
    total += sw[0].n_chk + sw[1].n_chk + sw[2].n_chk;
    bad   += sw[0].n_bad + sw[1].n_bad + sw[2].n_bad;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    m_last    = 3;
    m_ov      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    inv_mask  = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_inversion();
    test_backpressure();
    test_sparse();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
